rv_iopmp_entry_encoder: RTL
===========================

Name: rv_iopmp_entry_encoder

Overview:
- Programming engine that converts a byte region (base, length, permissions) into IOPMP entry register contents: the inverse of the entry match decode.
- Picks NA4, NAPOT or TOR encoding, then issues ADDR/ADDRH/CFG writes to the entry table over a valid/ready register-write port.
- Sits between the firmware-assist/config path and the IOPMP entry register file.

Parameters:
- ADDR_WIDTH, 64, width of region base and length (max 64)
- LEN, 32, width of one entry register word (ADDR, ADDRH, CFG)
- NUM_ENTRIES, 16, number of entries; IDX_W = $clog2(NUM_ENTRIES)

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  synchronous, active-low reset
- req_valid_i  in  1  region request valid
- req_ready_o  out  1  encoder idle, request accepted when valid&ready
- base_i  in  ADDR_WIDTH  region start byte address
- len_i  in  ADDR_WIDTH  region length in bytes
- idx_i  in  IDX_W  target entry index
- perm_i  in  3  access permissions {x,w,r}
- wr_valid_o  out  1  register write valid
- wr_ready_i  in  1  register file accepts write
- wr_idx_o  out  IDX_W  entry index written
- wr_sel_o  out  2  0=ADDR, 1=ADDRH, 2=CFG
- wr_data_o  out  LEN  write data
- done_o  out  1  one-cycle completion pulse
- err_o  out  1  request rejected (valid with done_o)
- mode_o  out  2  chosen mode (valid with done_o): OFF=0, TOR=1, NA4=2, NAPOT=3

Behaviour:
- Reset: req_ready_o=1, wr_valid_o=0, wr_idx_o=0, wr_sel_o=0, wr_data_o=0, done_o=0, err_o=0, mode_o=0; FSM in IDLE.
- FSM: IDLE -> CLASSIFY -> [WR_PREV_ADDR -> WR_PREV_ADDRH -> WR_PREV_CFG] -> WR_ADDR -> WR_ADDRH -> WR_CFG -> DONE -> IDLE. On error, CLASSIFY -> DONE.
- IDLE: req_ready_o=1; on accept, register base, len, idx, perm. req_ready_o=0 in every other state.
- CLASSIFY (1 cycle), using limit = base+len computed in ADDR_WIDTH+1 bits:
  - Error if len==0, base[1:0]!=0, len[1:0]!=0, or limit > 2^ADDR_WIDTH.
  - NA4 if len==4.
  - NAPOT if len is a power of two >= 8 and base is aligned to len.
  - Otherwise TOR. TOR is an error if idx==0 and base!=0.
- Entry address word E, 2*LEN bits:
  - NA4: E = base>>2.
  - NAPOT: E = (base>>2) | ((len>>3)-1), i.e. log2(len)-3 trailing ones.
  - TOR current entry: E = limit>>2. A limit of 2^64 gives E=2^62, which fits.
  - TOR previous entry (idx-1): E = base>>2.
- Write data: ADDR = E[LEN-1:0]; ADDRH = E[2LEN-1:LEN]; CFG = {zeros, mode[1:0], perm[2:0]}.
- TOR with idx>0 first writes entry idx-1: ADDR, ADDRH, then CFG=0 (OFF). TOR with idx==0 and base==0 skips the previous-entry writes.
- Write handshake: each WR_* state drives wr_valid_o=1. wr_idx_o, wr_sel_o and wr_data_o are registered and stay stable until wr_valid_o&wr_ready_i; the FSM advances on that cycle.
- DONE: done_o=1 with err_o/mode_o for one cycle, then IDLE. err_o=0 and mode_o=0 outside DONE.
- Latency with wr_ready_i tied 1, accept at cycle 0:
  - first write at cycle 2;
  - NA4/NAPOT done at cycle 5;
  - TOR with previous entry done at cycle 8;
  - error done at cycle 2, with no writes.
- A request held during a busy period is not accepted; req_valid_i needs no stability while req_ready_o=0.
- Reset asserted in any state: next cycle is IDLE with reset output values. A partially written entry is left as is.

Optional Feature:
- RV_IOPMP_ENCODER_TOR_FALLBACK_EN.
- Defined: behaviour as above; non-NA4/non-NAPOT regions fall back to TOR.
- Undefined: any region that would need TOR is rejected (err_o=1, no writes) and the WR_PREV_* states are not built.

Test Plan:
- NAPOT: base=0x8000_0000, len=0x1000, idx=3, perm=3'b011 -> writes idx3: ADDR=0x2000_01FF, ADDRH=0x0, CFG=0x1B; done_o at cycle 5, mode_o=3, err_o=0.
- NA4 and high address:
  - base=0x1000_0004, len=4, idx=0, perm=001 -> ADDR=0x0400_0001, ADDRH=0, CFG=0x11, mode_o=2.
  - base=0x4_0000_0000, len=0x1_0000_0000 -> ADDR=0x1FFF_FFFF, ADDRH=0x1, mode_o=3.
- TOR (macro defined): base=0x1000, len=0x3000, idx=5, perm=111 -> idx4: ADDR=0x400, ADDRH=0, CFG=0x00; then idx5: ADDR=0x1000, ADDRH=0, CFG=0x0F; done at cycle 8. Macro undefined -> err_o=1, zero writes.
- Errors, each giving done_o at cycle 2, err_o=1, no wr_valid_o:
  - len=0;
  - base=0x2, len=4;
  - TOR at idx=0 with base=0x1000, len=0x3000.
- Backpressure: NAPOT case with wr_ready_i=0 for 5 cycles during the ADDRH write -> wr_idx_o/wr_sel_o/wr_data_o unchanged throughout; done_o at cycle 10.
- Reset mid-op: rst_ni=0 for 1 cycle while in WR_ADDRH -> next cycle wr_valid_o=0, req_ready_o=1, done_o=0; a fresh request then completes normally.

Source files
------------

// File: rtl/rv_iopmp_entry_encoder.sv
// IOPMP entry programming engine: turns a (base, len, perm) byte region into NA4/NAPOT/TOR
// entry register writes. Define RV_IOPMP_ENCODER_TOR_FALLBACK_EN to allow TOR encoding.
module rv_iopmp_entry_encoder #(
  parameter int ADDR_WIDTH  = 64,
  parameter int LEN         = 32,
  parameter int NUM_ENTRIES = 16,
  localparam int IDX_W      = $clog2(NUM_ENTRIES)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [ADDR_WIDTH-1:0] base_i,
  input  logic [ADDR_WIDTH-1:0] len_i,
  input  logic [IDX_W-1:0]      idx_i,
  input  logic [2:0]            perm_i,
  output logic                  wr_valid_o,
  input  logic                  wr_ready_i,
  output logic [IDX_W-1:0]      wr_idx_o,
  output logic [1:0]            wr_sel_o,
  output logic [LEN-1:0]        wr_data_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic [1:0]            mode_o
);

  // state          | meaning
  // IDLE           | ready for a region request
  // CLASSIFY       | pick mode, build entry word, detect errors
  // WR_PREV_ADDR   | TOR: write base>>2 low word to entry idx-1
  // WR_PREV_ADDRH  | TOR: write base>>2 high word to entry idx-1
  // WR_PREV_CFG    | TOR: switch entry idx-1 OFF
  // WR_ADDR        | write entry word low half to entry idx
  // WR_ADDRH       | write entry word high half to entry idx
  // WR_CFG         | write {mode, perm} to entry idx
  // DONE           | one-cycle done pulse with err/mode
  typedef enum logic [3:0] {
    S_IDLE,
    S_CLASSIFY,
`ifdef RV_IOPMP_ENCODER_TOR_FALLBACK_EN
    S_WR_PREV_ADDR,
    S_WR_PREV_ADDRH,
    S_WR_PREV_CFG,
`endif
    S_WR_ADDR,
    S_WR_ADDRH,
    S_WR_CFG,
    S_DONE
  } state_t;

  localparam int EW = 2 * LEN;

  localparam logic [1:0] MODE_OFF   = 2'd0;
  localparam logic [1:0] MODE_TOR   = 2'd1;
  localparam logic [1:0] MODE_NA4   = 2'd2;
  localparam logic [1:0] MODE_NAPOT = 2'd3;

  localparam logic [1:0] SEL_ADDR  = 2'd0;
  localparam logic [1:0] SEL_ADDRH = 2'd1;
  localparam logic [1:0] SEL_CFG   = 2'd2;

  state_t                state_q;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [ADDR_WIDTH-1:0] len_q;
  logic [IDX_W-1:0]      idx_q;
  logic [2:0]            perm_q;
  logic [1:0]            mode_q;
  logic [EW-1:0]         e_q;

  logic [ADDR_WIDTH:0]   limit;
  logic [ADDR_WIDTH-1:0] len_m1;
  logic                  len_zero;
  logic                  limit_over;
  logic                  bad;
  logic                  is_na4;
  logic                  is_napot;
  logic [EW-1:0]         e_base;
  logic [EW-1:0]         e_mask;
  logic                  cls_err;
  logic [1:0]            cls_mode;
  logic [EW-1:0]         cls_e;
  logic [LEN-1:0]        cfg_word;
`ifdef RV_IOPMP_ENCODER_TOR_FALLBACK_EN
  logic                  cls_prev;
`endif

  // limit carries one extra bit so a region ending exactly at 2^ADDR_WIDTH is legal
  assign limit      = {1'b0, base_q} + {1'b0, len_q};
  assign len_m1     = len_q - ADDR_WIDTH'(1);
  assign len_zero   = (len_q == '0);
  assign limit_over = limit[ADDR_WIDTH] && (limit[ADDR_WIDTH-1:0] != '0);
  assign bad        = len_zero || (base_q[1:0] != 2'b00) || (len_q[1:0] != 2'b00) || limit_over;
  assign is_na4     = (len_q == ADDR_WIDTH'(4));
  assign is_napot   = !len_zero && ((len_q & len_m1) == '0) && (len_q >= ADDR_WIDTH'(8)) &&
                      ((base_q & len_m1) == '0);
  assign e_base     = EW'(base_q >> 2);
  assign e_mask     = EW'((len_q >> 3) - ADDR_WIDTH'(1));
  assign cfg_word   = LEN'({mode_q, perm_q});

  always_comb begin
    cls_err  = 1'b0;
    cls_mode = MODE_OFF;
    cls_e    = '0;
`ifdef RV_IOPMP_ENCODER_TOR_FALLBACK_EN
    cls_prev = 1'b0;
`endif
    if (bad) begin
      cls_err = 1'b1;
    end else if (is_na4) begin
      cls_mode = MODE_NA4;
      cls_e    = e_base;
    end else if (is_napot) begin
      cls_mode = MODE_NAPOT;
      cls_e    = e_base | e_mask;
    end else begin
`ifdef RV_IOPMP_ENCODER_TOR_FALLBACK_EN
      // entry 0 in TOR implicitly starts at address 0
      if ((idx_q == '0) && (base_q != '0)) begin
        cls_err = 1'b1;
      end else begin
        cls_mode = MODE_TOR;
        cls_e    = EW'(limit >> 2);
        cls_prev = (idx_q != '0);
      end
`else
      cls_err = 1'b1;
`endif
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      req_ready_o <= 1'b1;
      wr_valid_o  <= 1'b0;
      wr_idx_o    <= '0;
      wr_sel_o    <= SEL_ADDR;
      wr_data_o   <= '0;
      done_o      <= 1'b0;
      err_o       <= 1'b0;
      mode_o      <= MODE_OFF;
      base_q      <= '0;
      len_q       <= '0;
      idx_q       <= '0;
      perm_q      <= '0;
      mode_q      <= MODE_OFF;
      e_q         <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid_i && req_ready_o) begin
            base_q      <= base_i;
            len_q       <= len_i;
            idx_q       <= idx_i;
            perm_q      <= perm_i;
            req_ready_o <= 1'b0;
            state_q     <= S_CLASSIFY;
          end
        end
        S_CLASSIFY: begin
          mode_q <= cls_mode;
          e_q    <= cls_e;
          if (cls_err) begin
            done_o  <= 1'b1;
            err_o   <= 1'b1;
            mode_o  <= MODE_OFF;
            state_q <= S_DONE;
`ifdef RV_IOPMP_ENCODER_TOR_FALLBACK_EN
          end else if (cls_prev) begin
            wr_valid_o <= 1'b1;
            wr_idx_o   <= idx_q - IDX_W'(1);
            wr_sel_o   <= SEL_ADDR;
            wr_data_o  <= e_base[LEN-1:0];
            state_q    <= S_WR_PREV_ADDR;
`endif
          end else begin
            wr_valid_o <= 1'b1;
            wr_idx_o   <= idx_q;
            wr_sel_o   <= SEL_ADDR;
            wr_data_o  <= cls_e[LEN-1:0];
            state_q    <= S_WR_ADDR;
          end
        end
`ifdef RV_IOPMP_ENCODER_TOR_FALLBACK_EN
        S_WR_PREV_ADDR: begin
          if (wr_ready_i) begin
            wr_sel_o  <= SEL_ADDRH;
            wr_data_o <= e_base[EW-1:LEN];
            state_q   <= S_WR_PREV_ADDRH;
          end
        end
        S_WR_PREV_ADDRH: begin
          if (wr_ready_i) begin
            wr_sel_o  <= SEL_CFG;
            wr_data_o <= '0;
            state_q   <= S_WR_PREV_CFG;
          end
        end
        S_WR_PREV_CFG: begin
          if (wr_ready_i) begin
            wr_idx_o  <= idx_q;
            wr_sel_o  <= SEL_ADDR;
            wr_data_o <= e_q[LEN-1:0];
            state_q   <= S_WR_ADDR;
          end
        end
`endif
        S_WR_ADDR: begin
          if (wr_ready_i) begin
            wr_sel_o  <= SEL_ADDRH;
            wr_data_o <= e_q[EW-1:LEN];
            state_q   <= S_WR_ADDRH;
          end
        end
        S_WR_ADDRH: begin
          if (wr_ready_i) begin
            wr_sel_o  <= SEL_CFG;
            wr_data_o <= cfg_word;
            state_q   <= S_WR_CFG;
          end
        end
        S_WR_CFG: begin
          if (wr_ready_i) begin
            wr_valid_o <= 1'b0;
            done_o     <= 1'b1;
            err_o      <= 1'b0;
            mode_o     <= mode_q;
            state_q    <= S_DONE;
          end
        end
        S_DONE: begin
          done_o      <= 1'b0;
          err_o       <= 1'b0;
          mode_o      <= MODE_OFF;
          req_ready_o <= 1'b1;
          state_q     <= S_IDLE;
        end
        default: begin
          wr_valid_o  <= 1'b0;
          done_o      <= 1'b0;
          err_o       <= 1'b0;
          mode_o      <= MODE_OFF;
          req_ready_o <= 1'b1;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

endmodule
